uart_rx_frame_ctrl: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/uart_rx_frame_ctrl_if.sv | 45 ++++
 rtl/uart_frame_timer.sv | 30 +++
 rtl/uart_rx_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state type, default sync marker and width helper
// for the UART RX frame controller.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      HUNT,
      LEN,
      PAYLOAD,
      CSUM,
      HOLD
   } state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: byte input, frame buffer and status bundle.
// Counter ports exist only with UART_RX_FRAME_STATS_EN defined.
interface uart_rx_frame_ctrl_if #(
   parameter int MAX_LEN = 16
);
   import uart_frame_pkg::*;

   localparam int LW = len_w(MAX_LEN);
   localparam int AW = $clog2(MAX_LEN);

   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          frame_valid;
   logic [LW-1:0] frame_len;
   logic          frame_ack;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          err_checksum;
   logic          err_len;
   logic          err_timeout;
   logic [7:0]    overrun_cnt;
`ifdef UART_RX_FRAME_STATS_EN
   logic [15:0]   good_cnt;
   logic [15:0]   bad_cnt;
`endif

   modport slave (
      input  rx_data, rx_ready, frame_ack, rd_addr,
      output frame_valid, frame_len, rd_data,
      output err_checksum, err_len, err_timeout, overrun_cnt
`ifdef UART_RX_FRAME_STATS_EN
      , output good_cnt, bad_cnt
`endif
   );

   modport master (
      output rx_data, rx_ready, frame_ack, rd_addr,
      input  frame_valid, frame_len, rd_data,
      input  err_checksum, err_len, err_timeout, overrun_cnt
`ifdef UART_RX_FRAME_STATS_EN
      , input good_cnt, bad_cnt
`endif
   );

endinterface

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: inter-byte watchdog; expired pulses when the count
// sits at TIMEOUT_CYCLES-1 with no clear in that cycle.
module uart_frame_timer #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear || !enable) begin
         cnt_q <= '0;
      end else if (cnt_q != LAST) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: SYNC/LEN/payload/CSUM framer with hold-until-ack
// buffer. Define UART_RX_FRAME_STATS_EN for good/bad frame counters.
module uart_rx_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter int         MAX_LEN        = 16,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input logic                 clk,
   input logic                 reset_n,
   uart_rx_frame_ctrl_if.slave bus
);

   localparam int LW = len_w(MAX_LEN);
   localparam int AW = $clog2(MAX_LEN);

   state_e        state_q;
   logic [LW-1:0] len_q;
   logic [LW-1:0] idx_q;
   logic [7:0]    acc_q;
   logic [7:0]    ovr_q;
   logic [7:0]    rd_q;
   logic          valid_q;
   logic          err_cs_q;
   logic          err_len_q;
   logic          err_to_q;
   logic [7:0]    buf_q [MAX_LEN];

   logic rdy;
   logic sync_hit;
   logic len_bad;
   logic sum_ok;
   logic sum_bad;
   logic last_pay;
   logic tmr_en;
   logic expired;

   assign rdy      = bus.rx_ready;
   assign sync_hit = rdy && (bus.rx_data == SYNC_BYTE);
   assign len_bad  = (state_q == LEN) && rdy && (bus.rx_data > 8'(MAX_LEN));
   assign sum_ok   = (state_q == CSUM) && rdy && (bus.rx_data == acc_q);
   assign sum_bad  = (state_q == CSUM) && rdy && (bus.rx_data != acc_q);
   assign last_pay = (idx_q + LW'(1)) == len_q;
   assign tmr_en   = (state_q == LEN) || (state_q == PAYLOAD) ||
                     (state_q == CSUM);

   uart_frame_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (rdy),
      .enable (tmr_en),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= HUNT;
         len_q     <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         ovr_q     <= '0;
         valid_q   <= 1'b0;
         err_cs_q  <= 1'b0;
         err_len_q <= 1'b0;
         err_to_q  <= 1'b0;
      end else begin
         err_cs_q  <= sum_bad;
         err_len_q <= len_bad;
         err_to_q  <= expired;
         unique case (state_q)
            HUNT: begin
               if (sync_hit) state_q <= LEN;
            end
            LEN: begin
               if (len_bad) begin
                  state_q <= HUNT;
               end else if (rdy) begin
                  len_q   <= bus.rx_data[LW-1:0];
                  acc_q   <= bus.rx_data;
                  idx_q   <= '0;
                  state_q <= (bus.rx_data == 8'd0) ? CSUM : PAYLOAD;
               end else if (expired) begin
                  state_q <= HUNT;
               end
            end
            PAYLOAD: begin
               if (rdy) begin
                  acc_q <= acc_q ^ bus.rx_data;
                  idx_q <= idx_q + LW'(1);
                  if (last_pay) state_q <= CSUM;
               end else if (expired) begin
                  state_q <= HUNT;
               end
            end
            CSUM: begin
               if (sum_ok) begin
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end else if (sum_bad || expired) begin
                  state_q <= HUNT;
               end
            end
            HOLD: begin
               // ack wins; a byte in the same cycle is treated as a HUNT byte
               if (bus.frame_ack) begin
                  valid_q <= 1'b0;
                  state_q <= sync_hit ? LEN : HUNT;
               end else if (rdy && (ovr_q != 8'hFF)) begin
                  ovr_q <= ovr_q + 8'd1;
               end
            end
            default: state_q <= HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == PAYLOAD) && rdy) begin
         buf_q[idx_q[AW-1:0]] <= bus.rx_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q <= '0;
      end else begin
         rd_q <= buf_q[bus.rd_addr];
      end
   end

   assign bus.frame_valid  = valid_q;
   assign bus.frame_len    = len_q;
   assign bus.rd_data      = rd_q;
   assign bus.err_checksum = err_cs_q;
   assign bus.err_len      = err_len_q;
   assign bus.err_timeout  = err_to_q;
   assign bus.overrun_cnt  = ovr_q;

`ifdef UART_RX_FRAME_STATS_EN
   logic [15:0] good_q;
   logic [15:0] bad_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         good_q <= '0;
         bad_q  <= '0;
      end else begin
         if (sum_ok && (good_q != 16'hFFFF)) good_q <= good_q + 16'd1;
         if ((len_bad || sum_bad || expired) && (bad_q != 16'hFFFF)) begin
            bad_q <= bad_q + 16'd1;
         end
      end
   end

   assign bus.good_cnt = good_q;
   assign bus.bad_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed vector table, corner sequences and a
// randomized byte stream checked against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

   localparam int ML = 16;
   localparam int TO = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_frame_ctrl_if #(.MAX_LEN(ML)) bus ();

   uart_rx_frame_ctrl #(
      .MAX_LEN       (ML),
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk    (clk),
      .reset_n(rst_n),
      .bus    (bus)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // reference model, works on whole frames rather than per-byte state
   bit         m_in, m_hold;
   logic [7:0] m_q[$];
   logic [7:0] m_held[$];
   int         m_sil;
   bit         m_valid, m_ec, m_el, m_et;
   int         m_len, m_ovr, m_good, m_bad;
   bit         m_rdchk;
   int         m_rd;

   task automatic model_reset();
      m_in = 0; m_hold = 0; m_q.delete(); m_held.delete(); m_sil = 0;
      m_valid = 0; m_ec = 0; m_el = 0; m_et = 0;
      m_len = 0; m_ovr = 0; m_good = 0; m_bad = 0;
      m_rdchk = 0; m_rd = 0;
   endtask

   task automatic model_step(input bit r, input logic [7:0] d, input bit ak,
                             input logic [3:0] a);
      logic [7:0] x;
      m_ec = 0; m_el = 0; m_et = 0;
      m_rdchk = m_hold && (int'(a) < m_held.size());
      if (m_rdchk) m_rd = m_held[a];
      if (m_hold) begin
         if (ak) begin
            m_hold = 0; m_valid = 0;
            if (r && d == 8'hA5) begin m_in = 1; m_q.delete(); m_sil = 0; end
         end else if (r && m_ovr < 255) begin
            m_ovr++;
         end
      end else if (!m_in) begin
         if (r && d == 8'hA5) begin m_in = 1; m_q.delete(); m_sil = 0; end
      end else if (r) begin
         m_q.push_back(d);
         m_sil = 0;
         if (m_q[0] > 8'(ML)) begin
            m_el = 1; m_in = 0;
         end else if (m_q.size() == int'(m_q[0]) + 2) begin
            x = 0;
            for (int i = 0; i < m_q.size() - 1; i++) x ^= m_q[i];
            if (x == d) begin
               m_hold = 1; m_valid = 1; m_len = m_q[0];
               m_held.delete();
               for (int i = 1; i < m_q.size() - 1; i++) m_held.push_back(m_q[i]);
               if (m_good < 65535) m_good++;
            end else begin
               m_ec = 1;
            end
            m_in = 0;
         end
      end else begin
         m_sil++;
         if (m_sil == TO) begin m_et = 1; m_in = 0; end
      end
      if ((m_ec || m_el || m_et) && m_bad < 65535) m_bad++;
   endtask

   task automatic compare_model();
      chk("m_valid", bus.frame_valid, m_valid);
      chk("m_errc", bus.err_checksum, m_ec);
      chk("m_errl", bus.err_len, m_el);
      chk("m_errt", bus.err_timeout, m_et);
      chk("m_ovr", bus.overrun_cnt, m_ovr);
      if (m_valid) chk("m_len", bus.frame_len, m_len);
      if (m_rdchk) chk("m_rd", bus.rd_data, m_rd);
`ifdef UART_RX_FRAME_STATS_EN
      chk("m_good", bus.good_cnt, m_good);
      chk("m_bad", bus.bad_cnt, m_bad);
`endif
   endtask

   task automatic tick(input bit r, input logic [7:0] d, input bit ak,
                       input logic [3:0] a, input bit cmp);
      bus.rx_ready = r; bus.rx_data = d; bus.frame_ack = ak; bus.rd_addr = a;
      model_step(r, d, ak, a);
      @(posedge clk);
      #1;
      bus.rx_ready = 0; bus.frame_ack = 0;
      if (cmp) compare_model();
   endtask

   task automatic send(input logic [7:0] d);
      tick(1, d, 0, 4'd0, 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, bus.frame_valid, 0);
      chk({tag, "_len"}, bus.frame_len, 0);
      chk({tag, "_rd"}, bus.rd_data, 0);
      chk({tag, "_errc"}, bus.err_checksum, 0);
      chk({tag, "_errl"}, bus.err_len, 0);
      chk({tag, "_errt"}, bus.err_timeout, 0);
      chk({tag, "_ovr"}, bus.overrun_cnt, 0);
   endtask

   typedef struct {
      bit r; logic [7:0] d; bit ak; logic [3:0] a;
      bit v; int len; bit ec; bit el; bit et; int ovr; int rd;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(bit r, logic [7:0] d, bit ak, logic [3:0] a,
                               bit v, int len, bit ec, bit el, bit et,
                               int ovr, int rd);
      vec_t t;
      t.r = r; t.d = d; t.ak = ak; t.a = a; t.v = v; t.len = len;
      t.ec = ec; t.el = el; t.et = et; t.ovr = ovr; t.rd = rd;
      tbl.push_back(t);
   endfunction

   typedef struct { logic [7:0] d; int gap; } src_t;
   src_t src[$];
   int   ntrunc = 0;

   task automatic push_b(input logic [7:0] d, input int gap);
      src_t s;
      s.d = d; s.gap = gap;
      src.push_back(s);
   endtask

   task automatic build_chunk();
      int k, n, len;
      logic [7:0] cs, b;
      k = $urandom_range(0, 99);
      if (k < 70 || k >= 93) begin
         len = $urandom_range(0, ML);
         cs = 8'(len);
         push_b(8'hA5, $urandom_range(0, 3));
         push_b(8'(len), $urandom_range(0, 3));
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            cs ^= b;
            push_b(b, $urandom_range(0, 3));
         end
         if (k >= 93 && ntrunc < 3) begin
            ntrunc++;
            src[$].gap = TO + $urandom_range(0, 5);
         end else begin
            if (k >= 80) cs ^= 8'($urandom_range(1, 255));
            push_b(cs, $urandom_range(0, 4));
         end
      end else if (k < 80) begin
         push_b(8'hA5, $urandom_range(0, 2));
         push_b(8'($urandom_range(ML + 1, 255)), $urandom_range(0, 3));
      end else begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) push_b(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      end
   endtask

   task automatic run_random(input int cycles);
      int gap;
      bit r, ak;
      logic [7:0] d;
      logic [3:0] a;
      src_t it;
      gap = 0;
      for (int c = 0; c < cycles; c++) begin
         r = 0; d = 8'h00;
         ak = m_hold && ($urandom_range(0, 3) == 0);
         a = 4'($urandom_range(0, 15));
         if (gap > 0) begin
            gap--;
         end else begin
            if (src.size() == 0) build_chunk();
            it = src.pop_front();
            d = it.d; gap = it.gap; r = 1;
         end
         tick(r, d, ak, a, 1);
      end
   endtask

   initial begin
      logic [7:0] cs;
      bus.rx_ready = 0; bus.rx_data = 0; bus.frame_ack = 0; bus.rd_addr = 0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1;

      // r, d, ack, addr | valid, len, errc, errl, errt, ovr, rd
      add(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h33, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h03, 0, 0, 1, 3, 0, 0, 0, 0, -1);
      add(0, 8'h00, 0, 0, 1, 3, 0, 0, 0, 0, 8'h11);
      add(0, 8'h00, 0, 1, 1, 3, 0, 0, 0, 0, 8'h22);
      add(0, 8'h00, 0, 2, 1, 3, 0, 0, 0, 0, 8'h33);
      add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 8'h11);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h03, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h33, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h04, 0, 0, 0, 0, 1, 0, 0, 0, -1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, -1);
      add(1, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, -1);
      add(1, 8'h12, 0, 0, 1, 0, 0, 0, 0, 1, -1);
      add(1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 2, -1);
      add(1, 8'h77, 0, 0, 1, 0, 0, 0, 0, 3, -1);
      add(1, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 3, -1);
      add(1, 8'h01, 0, 0, 0, 0, 0, 0, 0, 3, -1);
      add(1, 8'h55, 0, 0, 0, 0, 0, 0, 0, 3, -1);
      add(1, 8'h54, 0, 0, 1, 1, 0, 0, 0, 3, -1);
      add(0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 3, 8'h55);
      add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 3, 8'h55);
      add(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 3, -1);
      add(1, 8'h11, 0, 0, 0, 0, 0, 1, 0, 3, -1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 3, -1);
      add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 3, -1);
      add(1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 3, -1);

      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].r, tbl[i].d, tbl[i].ak, tbl[i].a, 0);
         chk($sformatf("v%0d_valid", i), bus.frame_valid, tbl[i].v);
         if (tbl[i].v) chk($sformatf("v%0d_len", i), bus.frame_len, tbl[i].len);
         chk($sformatf("v%0d_errc", i), bus.err_checksum, tbl[i].ec);
         chk($sformatf("v%0d_errl", i), bus.err_len, tbl[i].el);
         chk($sformatf("v%0d_errt", i), bus.err_timeout, tbl[i].et);
         chk($sformatf("v%0d_ovr", i), bus.overrun_cnt, tbl[i].ovr);
         if (tbl[i].rd >= 0) chk($sformatf("v%0d_rd", i), bus.rd_data, tbl[i].rd);
      end

      // timeout: pulse on the TO-th edge after the last strobe's edge
      send(8'hA5); send(8'h02); send(8'h11);
      for (int k = 1; k <= TO; k++) begin
         tick(0, 8'h00, 0, 4'd0, 1);
         if (k == TO - 1) chk("to_early", bus.err_timeout, 0);
         if (k == TO) chk("to_fire", bus.err_timeout, 1);
      end
      tick(0, 8'h00, 0, 4'd0, 1);
      chk("to_end", bus.err_timeout, 0);

      // a strobe in the expiry cycle beats the timeout
      send(8'hA5); send(8'h02); send(8'h11);
      for (int k = 1; k < TO; k++) tick(0, 8'h00, 0, 4'd0, 1);
      send(8'h22);
      chk("to_suppress", bus.err_timeout, 0);
      send(8'h31);
      chk("to_sup_valid", bus.frame_valid, 1);
      chk("to_sup_len", bus.frame_len, 2);
      tick(0, 8'h00, 1, 4'd0, 1);

      // full-length frame and every read address
      send(8'hA5); send(8'(ML));
      cs = 8'(ML);
      for (int i = 0; i < ML; i++) begin
         send(8'(i * 37 + 5));
         cs ^= 8'(i * 37 + 5);
      end
      send(cs);
      chk("max_valid", bus.frame_valid, 1);
      chk("max_len", bus.frame_len, ML);
      for (int i = 0; i < ML; i++) tick(0, 8'h00, 0, 4'(i), 1);
      tick(0, 8'h00, 1, 4'd0, 1);

      // overrun saturation
      send(8'hA5); send(8'h00); send(8'h00);
      for (int i = 0; i < 260; i++) send(8'(i));
      chk("ovr_sat", bus.overrun_cnt, 255);
      tick(0, 8'h00, 1, 4'd0, 1);

      // asynchronous reset mid-frame
      send(8'hA5); send(8'h02); send(8'h11);
      #3;
      rst_n = 0;
      #1;
      check_zero("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1;
      send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h31);
      chk("post_rst_valid", bus.frame_valid, 1);
      chk("post_rst_len", bus.frame_len, 2);
      tick(0, 8'h00, 1, 4'd0, 1);

      run_random(8000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
